fifo_burst_arbiter: RTL and testbench
=====================================

Name: fifo_burst_arbiter

Overview:
Schedules burst reads from two host write-data FIFOs onto one shared NAND program datapath.
- Monitors each FIFO's fill count.
- Grants a fixed-length burst to an eligible FIFO, using round-robin when both are eligible.
- Paces reads with downstream backpressure.
- Produces per-FIFO almost-full flags with hysteresis for host flow control.
- Sits between the host-side data FIFOs and the flash-channel write engine.

Parameters:
NUM_W, 11, width of FIFO fill counts.
BURST_LEN, 256, words per burst; legal range 1..2^NUM_W-1.
HI_MARK, 1000, almost-full set threshold (count strictly greater than).
LO_MARK, 900, almost-full clear threshold (count strictly less than); LO_MARK < HI_MARK.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
fifo0_num  in  NUM_W  FIFO0 fill count
fifo1_num  in  NUM_W  FIFO1 fill count
dn_ready  in  1  downstream accepts a word this cycle
fifo0_rd_en  out  1  read strobe to FIFO0
fifo1_rd_en  out  1  read strobe to FIFO1
dn_valid  out  1  read data valid to downstream (rd_en delayed 1 cycle)
dn_sel  out  1  source of the current burst (0=FIFO0, 1=FIFO1)
burst_start  out  1  one-cycle pulse in GRANT
burst_done  out  1  one-cycle pulse in DONE
busy  out  1  state != IDLE
fifo0_afull  out  1  FIFO0 almost-full, hysteretic
fifo1_afull  out  1  FIFO1 almost-full, hysteretic

Behaviour:
- Reset values: all outputs 0; num_reg0/1 = 0; state = IDLE; word counter = 0; last_served = 1, so FIFO0 wins the first tie.
- Count sampling: fifoN_num is registered into num_regN every cycle. All decisions use num_regN, so there is 1 cycle of sample latency.
- Eligibility: eligN = (num_regN >= BURST_LEN). It is evaluated only in IDLE; count changes during a burst are ignored.
- FSM states: IDLE, GRANT, XFER, DONE.
- IDLE transitions:
  - If any eligN, go to GRANT and register dn_sel.
  - If both are eligible, pick !last_served.
  - Otherwise pick the single eligible FIFO.
- GRANT:
  - Lasts exactly 1 cycle; burst_start = 1; counter cleared.
  - Always goes to XFER.
- XFER:
  - fifo[dn_sel]_rd_en = dn_ready, combinational from registered state and dn_ready. The other rd_en is 0.
  - The counter increments on each rd_en.
  - When rd_en is high with counter == BURST_LEN-1, go to DONE. Exactly BURST_LEN reads are issued per burst.
  - While dn_ready = 0, the FSM stays in XFER with no reads and no timeout.
- DONE:
  - Lasts 1 cycle; burst_done = 1; last_served <= dn_sel.
  - Goes to IDLE. The earliest next GRANT is the cycle after IDLE, so at least 1 IDLE cycle separates bursts.
- dn_valid: registered copy of (fifo0_rd_en | fifo1_rd_en), matching the FIFO's 1-cycle read latency. The final dn_valid of a burst coincides with the DONE cycle.
- dn_sel: holds its value from GRANT through DONE and retains its last value in IDLE.
- Almost-full flags (per FIFO, independent of the FSM):
  - Set when num_regN > HI_MARK.
  - Clear when num_regN < LO_MARK.
  - Hold otherwise.
  - Registered, so total latency from the fifo_num change is 2 cycles.
- Counter width: NUM_W bits; the counter never wraps because it resets in GRANT.
- Reset asserted mid-burst: asynchronous return to reset state; rd_en drops immediately; the partially read burst is abandoned. Upstream recovery is not this block's concern.
- Underflow: cannot occur. The arbiter is the sole reader and eligibility guarantees at least BURST_LEN words.

Decomposition:
- Shared package: state encoding enum (IDLE/GRANT/XFER/DONE) and default BURST_LEN/HI_MARK/LO_MARK constants.
- One sub-module: afull_hyst (registered compare with set/clear hysteresis on one count), instantiated twice.

Test Plan:
- Reset, then fifo0_num=300, fifo1_num=0, dn_ready=1:
  - burst_start 2 cycles after num becomes valid; dn_sel=0.
  - Exactly 256 consecutive fifo0_rd_en; burst_done on the cycle after the last read.
  - dn_valid high for 256 cycles, lagging rd_en by 1.
- Both counts = 600, dn_ready=1, three bursts: dn_sel sequence 0,1,0; at least 1 IDLE cycle between burst_done and the next burst_start.
- In XFER, toggle dn_ready 1,0,0,1 repeatedly: rd_en mirrors dn_ready; total reads = 256; no read while dn_ready=0.
- fifo1_num ramps 950→1001→950→899→950:
  - fifo1_afull rises 2 cycles after 1001.
  - It stays 1 at 950, falls 2 cycles after 899, and stays 0 at 950.
- fifo0_num=255 (one below BURST_LEN): no grant, busy=0. Step to 256: grant follows.
- Assert reset_n=0 at read 100 of a burst: all outputs 0 immediately. After release with counts still 600, FIFO0 is granted first and a full 256-word burst is issued.

Source files
------------

// File: rtl/fifo_burst_arbiter_pkg.sv
// Shared types and default constants for the two-FIFO burst arbiter.
package fifo_burst_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    localparam int unsigned NUM_W_DEF     = 11;
    localparam int unsigned BURST_LEN_DEF = 256;
    localparam int unsigned HI_MARK_DEF   = 1000;
    localparam int unsigned LO_MARK_DEF   = 900;

endpackage

// File: rtl/fifo_burst_arbiter_afull.sv
// Registered almost-full flag with set/clear hysteresis on one sampled fill count.
module afull_hyst #(
    parameter int unsigned NUM_W   = 11,
    parameter int unsigned HI_MARK = 1000,
    parameter int unsigned LO_MARK = 900
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NUM_W-1:0] num,
    output logic             afull
);

    localparam logic [NUM_W-1:0] HI_C = NUM_W'(HI_MARK);
    localparam logic [NUM_W-1:0] LO_C = NUM_W'(LO_MARK);

    logic afull_r;
    logic afull_next_s;

    // Between the two marks the flag keeps its previous value.
    always_comb begin
        afull_next_s = afull_r;
        if (num > HI_C) begin
            afull_next_s = 1'b1;
        end else if (num < LO_C) begin
            afull_next_s = 1'b0;
        end else begin
            afull_next_s = afull_r;
        end
    end

    // Flag register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            afull_r <= 1'b0;
        end else begin
            afull_r <= afull_next_s;
        end
    end

    assign afull = afull_r;

endmodule

// File: rtl/fifo_burst_arbiter.sv
// Round-robin fixed-length burst scheduler from two host FIFOs onto one
// downstream program datapath, with hysteretic almost-full flags per FIFO.
module fifo_burst_arbiter
    import fifo_burst_arbiter_pkg::*;
#(
    parameter int unsigned NUM_W     = NUM_W_DEF,
    parameter int unsigned BURST_LEN = BURST_LEN_DEF,
    parameter int unsigned HI_MARK   = HI_MARK_DEF,
    parameter int unsigned LO_MARK   = LO_MARK_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NUM_W-1:0] fifo0_num,
    input  logic [NUM_W-1:0] fifo1_num,
    input  logic             dn_ready,
    output logic             fifo0_rd_en,
    output logic             fifo1_rd_en,
    output logic             dn_valid,
    output logic             dn_sel,
    output logic             burst_start,
    output logic             burst_done,
    output logic             busy,
    output logic             fifo0_afull,
    output logic             fifo1_afull
);

    localparam logic [NUM_W-1:0] BURST_C    = NUM_W'(BURST_LEN);
    localparam logic [NUM_W-1:0] BURST_M1_C = NUM_W'(BURST_LEN - 1);

    arb_state_e       state_r, state_next_s;
    logic [NUM_W-1:0] num0_r, num1_r;
    logic [NUM_W-1:0] cnt_r, cnt_next_s;
    logic             sel_r, sel_next_s;
    logic             last_served_r, last_served_next_s;
    logic             dn_valid_r;
    logic             elig0_s, elig1_s;
    logic             rd_en_s;

    assign elig0_s = (num0_r >= BURST_C);
    assign elig1_s = (num1_r >= BURST_C);
    assign rd_en_s = (state_r == ST_XFER) & dn_ready;

    // Next-state, counter and grant selection.
    always_comb begin
        state_next_s       = state_r;
        cnt_next_s         = cnt_r;
        sel_next_s         = sel_r;
        last_served_next_s = last_served_r;
        case (state_r)
            ST_IDLE: begin
                if (elig0_s && elig1_s) begin
                    state_next_s = ST_GRANT;
                    sel_next_s   = ~last_served_r;
                end else if (elig0_s) begin
                    state_next_s = ST_GRANT;
                    sel_next_s   = 1'b0;
                end else if (elig1_s) begin
                    state_next_s = ST_GRANT;
                    sel_next_s   = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                cnt_next_s   = '0;
                state_next_s = ST_XFER;
            end
            ST_XFER: begin
                if (rd_en_s) begin
                    cnt_next_s = cnt_r + NUM_W'(1);
                    if (cnt_r == BURST_M1_C) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_XFER;
                    end
                end else begin
                    state_next_s = ST_XFER;
                end
            end
            ST_DONE: begin
                last_served_next_s = sel_r;
                state_next_s       = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, counter, count samples and the dn_valid pipeline stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            sel_r         <= 1'b0;
            last_served_r <= 1'b1;
            num0_r        <= '0;
            num1_r        <= '0;
            dn_valid_r    <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            cnt_r         <= cnt_next_s;
            sel_r         <= sel_next_s;
            last_served_r <= last_served_next_s;
            num0_r        <= fifo0_num;
            num1_r        <= fifo1_num;
            dn_valid_r    <= rd_en_s;
        end
    end

    afull_hyst #(.NUM_W(NUM_W), .HI_MARK(HI_MARK), .LO_MARK(LO_MARK)) u_afull0 (
        .clk     (clk),
        .reset_n (reset_n),
        .num     (num0_r),
        .afull   (fifo0_afull)
    );

    afull_hyst #(.NUM_W(NUM_W), .HI_MARK(HI_MARK), .LO_MARK(LO_MARK)) u_afull1 (
        .clk     (clk),
        .reset_n (reset_n),
        .num     (num1_r),
        .afull   (fifo1_afull)
    );

    // Read strobes follow dn_ready directly so reads pace with backpressure.
    assign fifo0_rd_en = rd_en_s & ~sel_r;
    assign fifo1_rd_en = rd_en_s &  sel_r;
    assign dn_valid    = dn_valid_r;
    assign dn_sel      = sel_r;
    assign burst_start = (state_r == ST_GRANT);
    assign burst_done  = (state_r == ST_DONE);
    assign busy        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Directed self-checking bench for fifo_burst_arbiter (BURST_LEN=256, marks 1000/900).
module tb_fifo_burst_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] fifo0_num;
    logic [10:0] fifo1_num;
    logic        dn_ready;
    logic        fifo0_rd_en, fifo1_rd_en, dn_valid, dn_sel;
    logic        burst_start, burst_done, busy, fifo0_afull, fifo1_afull;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    fifo_burst_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fifo0_num   (fifo0_num),
        .fifo1_num   (fifo1_num),
        .dn_ready    (dn_ready),
        .fifo0_rd_en (fifo0_rd_en),
        .fifo1_rd_en (fifo1_rd_en),
        .dn_valid    (dn_valid),
        .dn_sel      (dn_sel),
        .burst_start (burst_start),
        .burst_done  (burst_done),
        .busy        (busy),
        .fifo0_afull (fifo0_afull),
        .fifo1_afull (fifo1_afull)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({fifo0_rd_en, fifo1_rd_en, dn_valid, dn_sel, burst_start,
                    burst_done, busy, fifo0_afull, fifo1_afull});
    endfunction

    // Waits for a grant, runs one burst to its DONE cycle and checks it; returns in DONE.
    task automatic do_burst(input logic exp_sel, input bit stall, input string tag);
        int   n, rd, oth, dv, mis, lag, ph;
        logic prev_rd, cur, other;
        n = 0;
        while (burst_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, " start"}, 32'(burst_start), 32'd1);
        check({tag, " sel"}, 32'(dn_sel), 32'(exp_sel));
        rd = 0; oth = 0; dv = 0; mis = 0; lag = 0; ph = 0;
        prev_rd = 1'b0;
        tick();
        n = 0;
        while (burst_done !== 1'b1 && n < 3000) begin
            if (stall) dn_ready = (ph == 1 || ph == 2) ? 1'b0 : 1'b1;
            ph = (ph + 1) % 4;
            #1;
            cur   = exp_sel ? fifo1_rd_en : fifo0_rd_en;
            other = exp_sel ? fifo0_rd_en : fifo1_rd_en;
            if (cur !== dn_ready) mis++;
            if (dn_valid !== prev_rd) lag++;
            if (cur === 1'b1) rd++;
            if (other === 1'b1) oth++;
            if (dn_valid === 1'b1) dv++;
            prev_rd = cur;
            tick();
            n++;
        end
        dn_ready = 1'b1;
        #1;
        if (dn_valid !== prev_rd) lag++;
        if (dn_valid === 1'b1) dv++;
        check({tag, " done"}, 32'(burst_done), 32'd1);
        check({tag, " reads"}, 32'(rd), 32'd256);
        check({tag, " other_rd"}, 32'(oth), 32'd0);
        check({tag, " rd_mirror"}, 32'(mis), 32'd0);
        check({tag, " dv_lag"}, 32'(lag), 32'd0);
        check({tag, " dv_cnt"}, 32'(dv), 32'd256);
        check({tag, " done_after_last"}, 32'(prev_rd), 32'd1);
        check({tag, " rd_in_done"}, 32'({fifo0_rd_en, fifo1_rd_en}), 32'd0);
        check({tag, " sel_hold"}, 32'(dn_sel), 32'(exp_sel));
    endtask

    task automatic idle_gap(input string tag);
        tick();
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        check({tag, " idle_start"}, 32'(burst_start), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            tick();
            n++;
        end
        tick();
        check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n, rd;
        reset_n   = 1'b0;
        fifo0_num = 11'd0;
        fifo1_num = 11'd0;
        dn_ready  = 1'b1;
        tick();
        tick();
        check("reset outs", all_outs(), 32'd0);
        reset_n = 1'b1;
        tick();
        check("post_reset busy", 32'(busy), 32'd0);

        // Single eligible FIFO0, two-cycle grant latency.
        fifo0_num = 11'd300;
        tick();
        check("t1 start_early", 32'(burst_start), 32'd0);
        tick();
        check("t1 start_lat", 32'(burst_start), 32'd1);
        do_burst(1'b0, 1'b0, "t1");
        fifo0_num = 11'd0;
        idle_gap("t1");
        tick();
        check("t1 no_regrant", 32'(busy), 32'd0);

        // Round robin from a fresh reset: 0,1,0.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        fifo0_num = 11'd600;
        fifo1_num = 11'd600;
        do_burst(1'b0, 1'b0, "rr0");
        idle_gap("rr0");
        do_burst(1'b1, 1'b0, "rr1");
        idle_gap("rr1");
        do_burst(1'b0, 1'b0, "rr2");
        fifo0_num = 11'd0;
        fifo1_num = 11'd0;
        idle_gap("rr2");

        // Backpressure pattern 1,0,0,1 on FIFO1.
        fifo1_num = 11'd600;
        do_burst(1'b1, 1'b1, "stall");
        fifo1_num = 11'd0;
        idle_gap("stall");

        // Hysteresis on FIFO1; FIFO0 sits exactly at HI_MARK and must stay clear.
        fifo0_num = 11'd1000;
        fifo1_num = 11'd950;
        tick(); tick(); tick();
        check("af 950 init", 32'(fifo1_afull), 32'd0);
        fifo1_num = 11'd1001;
        tick();
        check("af 1001 +1", 32'(fifo1_afull), 32'd0);
        tick();
        check("af 1001 +2", 32'(fifo1_afull), 32'd1);
        check("af0 at 1000", 32'(fifo0_afull), 32'd0);
        fifo1_num = 11'd950;
        tick(); tick(); tick();
        check("af 950 hold1", 32'(fifo1_afull), 32'd1);
        fifo1_num = 11'd899;
        tick();
        check("af 899 +1", 32'(fifo1_afull), 32'd1);
        tick();
        check("af 899 +2", 32'(fifo1_afull), 32'd0);
        fifo1_num = 11'd950;
        tick(); tick(); tick();
        check("af 950 hold0", 32'(fifo1_afull), 32'd0);
        fifo0_num = 11'd0;
        fifo1_num = 11'd0;
        wait_idle("af");

        // Eligibility boundary.
        fifo0_num = 11'd255;
        tick(); tick(); tick(); tick();
        check("b255 busy", 32'(busy), 32'd0);
        check("b255 start", 32'(burst_start), 32'd0);
        fifo0_num = 11'd256;
        do_burst(1'b0, 1'b0, "b256");
        fifo0_num = 11'd0;
        idle_gap("b256");

        // Reset at read 100 of a burst.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        fifo0_num = 11'd600;
        fifo1_num = 11'd600;
        n = 0;
        while (burst_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        rd = 0;
        n = 0;
        while (rd < 100 && n < 500) begin
            if (fifo0_rd_en === 1'b1) rd++;
            tick();
            n++;
        end
        check("mid rd_active", 32'(fifo0_rd_en), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid reset outs", all_outs(), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        do_burst(1'b0, 1'b0, "post_rst");
        fifo0_num = 11'd0;
        fifo1_num = 11'd0;
        idle_gap("post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
